// File: rtl/cic_ctrl_pkg.sv
// Shared constants for the CIC decimator sequencing controller.
package cic_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_WARMUP = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam int unsigned MIN_RATIO     = 2;
    localparam int unsigned DEFAULT_RATIO = 4;

endpackage

// File: rtl/cic_decim_ctrl_phase.sv
// Decimation phase counter: the registered wrap is high in the cycle the phase equals ratio-1.
module decim_phase_counter #(
    parameter int unsigned RATIO_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [RATIO_BITS-1:0] ratio,
    output logic                  wrap
);

    logic [RATIO_BITS-1:0] phase;
    logic [RATIO_BITS-1:0] phase_nxt;
    logic [RATIO_BITS-1:0] last;

    // enable means the next cycle counts; clear restarts the count from phase 0
    always_comb begin
        last      = ratio - RATIO_BITS'(1);
        phase_nxt = '0;
        if (enable && !clear && (phase != last)) begin
            phase_nxt = phase + RATIO_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
            wrap  <= 1'b0;
        end else begin
            phase <= phase_nxt;
            wrap  <= enable && (phase_nxt == last);
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: strobe/clear generation, comb warm-up discard and
// a single-entry valid/ready output register with sticky overrun.
module cic_decim_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int unsigned OUTPUT_BITS   = 16,
    parameter int unsigned RATIO_BITS    = 8,
    parameter int unsigned ORDER         = 2,
    parameter int unsigned DEFAULT_RATIO = cic_ctrl_pkg::DEFAULT_RATIO
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [RATIO_BITS-1:0]  cfg_ratio,
    input  logic                   cfg_load,
    output logic                   dec_strobe,
    output logic                   int_clear,
    input  logic [OUTPUT_BITS-1:0] filt_data,
    output logic [OUTPUT_BITS-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic [1:0]             state
);

    localparam int unsigned WARM_BITS = $clog2(ORDER + 1);

    logic [1:0]             state_nxt;
    logic [RATIO_BITS-1:0]  ratio_active;
    logic [RATIO_BITS-1:0]  ratio_nxt;
    logic [WARM_BITS-1:0]   warm_cnt;
    logic [WARM_BITS-1:0]   warm_nxt;
    logic                   cap_pending;
    logic                   cap_nxt;
    logic                   int_clear_nxt;
    logic [OUTPUT_BITS-1:0] out_data_nxt;
    logic                   out_valid_nxt;
    logic                   overrun_nxt;
    logic                   counting_now;
    logic                   counting_nxt;
    logic                   capture;
    logic                   accept;
    logic                   drop;

    decim_phase_counter #(
        .RATIO_BITS(RATIO_BITS)
    ) u_phase (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!counting_now),
        .enable (counting_nxt),
        .ratio  (ratio_active),
        .wrap   (dec_strobe)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_nxt = state;
        ratio_nxt = ratio_active;
        warm_nxt  = warm_cnt;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_nxt = en ? ST_WARMUP : ST_IDLE;
                ratio_nxt = (cfg_ratio < RATIO_BITS'(MIN_RATIO)) ? RATIO_BITS'(MIN_RATIO) : cfg_ratio;
                warm_nxt  = '0;
            end
            ST_WARMUP: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (cfg_load) begin
                    state_nxt = ST_FLUSH;
                end else if (dec_strobe) begin
                    warm_nxt = warm_cnt + WARM_BITS'(1);
                    if (warm_cnt == WARM_BITS'(ORDER - 1)) state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (cfg_load) begin
                    state_nxt = ST_FLUSH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        counting_now  = (state == ST_WARMUP) || (state == ST_RUN);
        counting_nxt  = (state_nxt == ST_WARMUP) || (state_nxt == ST_RUN);
        int_clear_nxt = (state_nxt == ST_FLUSH);

        // a RUN strobe schedules a capture only if the run continues
        cap_nxt = (state == ST_RUN) && dec_strobe && (state_nxt == ST_RUN);

        capture = cap_pending && en;
        accept  = out_valid && out_ready;
        drop    = capture && out_valid && !out_ready;

        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        if (capture) begin
            out_valid_nxt = 1'b1;
            if (!drop) out_data_nxt = filt_data;
        end else if (accept) begin
            out_valid_nxt = 1'b0;
        end
        overrun_nxt = drop || (overrun && !overrun_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ratio_active <= RATIO_BITS'(DEFAULT_RATIO);
            warm_cnt     <= '0;
            cap_pending  <= 1'b0;
            int_clear    <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nxt;
            ratio_active <= ratio_nxt;
            warm_cnt     <= warm_nxt;
            cap_pending  <= cap_nxt;
            int_clear    <= int_clear_nxt;
            out_data     <= out_data_nxt;
            out_valid    <= out_valid_nxt;
            overrun      <= overrun_nxt;
        end
    end

endmodule
